// File: rtl/program_counter_if.sv
// program_counter_if: decoder <-> program counter bus (ID_ink exists only when PC_INK_EN is defined)
interface program_counter_if #(
    parameter int W = 8
);
    logic         ID_rst;
`ifdef PC_INK_EN
    logic         ID_ink;
`endif
    logic         skok_pc;
    logic [7:0]   adres_skok_pc;
    logic [W-1:0] PC_count;

`ifdef PC_INK_EN
    modport master (output ID_rst, output ID_ink, output skok_pc, output adres_skok_pc, input PC_count);
    modport slave  (input ID_rst, input ID_ink, input skok_pc, input adres_skok_pc, output PC_count);
`else
    modport master (output ID_rst, output skok_pc, output adres_skok_pc, input PC_count);
    modport slave  (input ID_rst, input skok_pc, input adres_skok_pc, output PC_count);
`endif
endinterface

// File: rtl/program_counter.sv
// program_counter: mikroProcesor PC; clear > jump > increment, wraps mod 2^W.
// Optional macro PC_INK_EN adds ID_ink, gating the increment (hold when low).
module program_counter #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input logic                clk,
    input logic                rst,
    program_counter_if.slave   bus
);
    logic [W-1:0] target;
    logic [W-1:0] inc;
    logic [W-1:0] next;

    generate
        if (W > 8) begin : g_wide
            assign target = {{(W-8){1'b0}}, bus.adres_skok_pc};
        end else begin : g_narrow
            assign target = bus.adres_skok_pc[W-1:0];
        end
    endgenerate

`ifdef PC_INK_EN
    assign inc = bus.ID_ink ? bus.PC_count + W'(1) : bus.PC_count;
`else
    assign inc = bus.PC_count + W'(1);
`endif

    // next-value mux: decoder clear wins over jump, jump over increment
    always_comb begin
        next = bus.ID_rst ? RST_VAL : bus.skok_pc ? target : inc;
    end

    // PC register, asynchronously forced to RST_VAL while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bus.PC_count <= RST_VAL;
        else
            bus.PC_count <= next;
    end
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed test-plan cases plus random stimulus against an arithmetic PC model
module tb_program_counter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_pc;

    program_counter_if #(.W(8)) bus ();

    program_counter #(.W(8), .RST_VAL(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, want);
        end
    endtask

    // one clock: optional mid-low-phase async reset pulse, drive requests, advance model, check after edge
    task automatic step(input string tag, input logic c, input logic j, input logic [7:0] a,
                        input logic k, input logic ar);
        logic grow;
        @(negedge clk);
        if (ar) begin
            rst = 1'b0;
            #1;
            check("arst_pulse", bus.PC_count, 8'h00);
            exp_pc = 0;
            rst = 1'b1;
        end
        bus.ID_rst        = c;
        bus.skok_pc       = j;
        bus.adres_skok_pc = a;
`ifdef PC_INK_EN
        bus.ID_ink = k;
        grow = k;
`else
        grow = 1'b1;
`endif
        if (c)         exp_pc = 0;
        else if (j)    exp_pc = int'(a);
        else if (grow) exp_pc = (exp_pc + 1) % 256;
        @(posedge clk);
        #1;
        check(tag, bus.PC_count, 8'(exp_pc));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_pc = 0;
        rst = 1'b0;
        bus.ID_rst = 1'b0;
        bus.skok_pc = 1'b0;
        bus.adres_skok_pc = 8'h00;
`ifdef PC_INK_EN
        bus.ID_ink = 1'b1;
`endif
        #1;
        check("reset_state", bus.PC_count, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        step("jump_05", 1'b0, 1'b1, 8'h05, 1'b1, 1'b0);
        // asynchronous reset in the middle of a cycle
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", bus.PC_count, 8'h00);
        exp_pc = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold", bus.PC_count, 8'h00);
        end
        rst = 1'b1;
        #1;
        check("release", bus.PC_count, 8'h00);
        repeat (3) step("free_run", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step("jump_aa", 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
        repeat (2) step("after_jump", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step("jump_ff", 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
        repeat (2) step("wrap", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step("clr_vs_jump", 1'b1, 1'b1, 8'h40, 1'b1, 1'b0);
        step("jump_37", 1'b0, 1'b1, 8'h37, 1'b1, 1'b0);
        step("clr_only", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) step("jump_held", 1'b0, 1'b1, 8'h50, 1'b1, 1'b0);
`ifdef PC_INK_EN
        step("jump_10", 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
        repeat (3) step("ink_hold", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("ink_inc", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step("jump_no_ink", 1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
        step("clr_no_ink", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
`endif
        for (int i = 0; i < 300; i++) begin
            step("random",
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) == 0,
                 8'($urandom),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 24) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
